// File: rtl/triangle_raster_scan.sv
`default_nettype none
// ============================================================================
// Module      : triangle_raster_scan
// Description : Walks a triangle's bounding box in raster order and streams
//               every pixel on or inside its three edges (valid/ready).
// Revision    : 1.0  initial release
// ============================================================================
module triangle_raster_scan #(
    parameter int COORD_W = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COORD_W-1:0]     p1x,
    input  logic [COORD_W-1:0]     p1y,
    input  logic [COORD_W-1:0]     p2x,
    input  logic [COORD_W-1:0]     p2y,
    input  logic [COORD_W-1:0]     p3x,
    input  logic [COORD_W-1:0]     p3y,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COORD_W-1:0]     out_x,
    output logic [COORD_W-1:0]     out_y,
    output logic                   done,
    output logic [2*COORD_W-1:0]   pix_count
);
    localparam int c_DIFF_W = COORD_W + 1;
    localparam int c_PROD_W = 2 * COORD_W + 2;

    typedef enum logic [2:0] {IDLE, SETUP, SCAN, EMIT, FIN} state_t;

    state_t                 state_q;
    logic [COORD_W-1:0]     v1x_q, v1y_q, v2x_q, v2y_q, v3x_q, v3y_q;
    logic [COORD_W-1:0]     xmin_q, xmax_q, ymax_q;
    logic [COORD_W-1:0]     px_q, py_q;
    logic [COORD_W-1:0]     out_x_q, out_y_q;
    logic                   out_valid_q, done_q;
    logic [2*COORD_W-1:0]   pix_count_q;

    logic signed [c_PROD_W-1:0] w_e12, w_e23, w_e31, w_area;
    logic                   w_inside, w_last;
    logic [COORD_W-1:0]     w_nx, w_ny;

    // Vertex difference, sign-extended to the full product width so the
    // products and their difference are never truncated.
    function automatic logic signed [c_PROD_W-1:0] diff(
        input logic [COORD_W-1:0] b,
        input logic [COORD_W-1:0] a
    );
        logic signed [c_DIFF_W-1:0] d;
        d = $signed({1'b0, b}) - $signed({1'b0, a});
        return {{(c_PROD_W-c_DIFF_W){d[c_DIFF_W-1]}}, d};
    endfunction

    function automatic logic signed [c_PROD_W-1:0] edge_fn(
        input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
        input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by,
        input logic [COORD_W-1:0] qx, input logic [COORD_W-1:0] qy
    );
        return diff(bx, ax) * diff(qy, ay) - diff(by, ay) * diff(qx, ax);
    endfunction

    function automatic logic [COORD_W-1:0] min3(
        input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b,
        input logic [COORD_W-1:0] c
    );
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] max3(
        input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b,
        input logic [COORD_W-1:0] c
    );
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    always_comb begin
        w_e12  = edge_fn(v1x_q, v1y_q, v2x_q, v2y_q, px_q, py_q);
        w_e23  = edge_fn(v2x_q, v2y_q, v3x_q, v3y_q, px_q, py_q);
        w_e31  = edge_fn(v3x_q, v3y_q, v1x_q, v1y_q, px_q, py_q);
        w_area = edge_fn(v1x_q, v1y_q, v2x_q, v2y_q, v3x_q, v3y_q);
        // Either all edges non-negative or all non-positive: winding-agnostic.
        w_inside = (!w_e12[c_PROD_W-1] && !w_e23[c_PROD_W-1] && !w_e31[c_PROD_W-1])
                || ((w_e12[c_PROD_W-1] || w_e12 == '0)
                 && (w_e23[c_PROD_W-1] || w_e23 == '0)
                 && (w_e31[c_PROD_W-1] || w_e31 == '0));
        w_last = (px_q == xmax_q) && (py_q == ymax_q);
        if (px_q == xmax_q) begin
            w_nx = xmin_q;
            w_ny = py_q + 1'b1;
        end else begin
            w_nx = px_q + 1'b1;
            w_ny = py_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            pix_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        v1x_q       <= p1x;
                        v1y_q       <= p1y;
                        v2x_q       <= p2x;
                        v2y_q       <= p2y;
                        v3x_q       <= p3x;
                        v3y_q       <= p3y;
                        pix_count_q <= '0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    xmin_q  <= min3(v1x_q, v2x_q, v3x_q);
                    xmax_q  <= max3(v1x_q, v2x_q, v3x_q);
                    ymax_q  <= max3(v1y_q, v2y_q, v3y_q);
                    px_q    <= min3(v1x_q, v2x_q, v3x_q);
                    py_q    <= min3(v1y_q, v2y_q, v3y_q);
                    state_q <= (w_area == '0) ? FIN : SCAN;
                end
                SCAN: begin
                    if (w_inside) begin
                        out_x_q     <= px_q;
                        out_y_q     <= py_q;
                        out_valid_q <= 1'b1;
                        state_q     <= EMIT;
                    end else if (w_last) begin
                        state_q <= FIN;
                    end else begin
                        px_q <= w_nx;
                        py_q <= w_ny;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        pix_count_q <= pix_count_q + 1'b1;
                        out_valid_q <= 1'b0;
                        if (w_last) begin
                            state_q <= FIN;
                        end else begin
                            px_q    <= w_nx;
                            py_q    <= w_ny;
                            state_q <= SCAN;
                        end
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign done      = done_q;
    assign pix_count = pix_count_q;

endmodule
`default_nettype wire

// File: tb/tb_triangle_raster_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_triangle_raster_scan
// Description : Randomized self-checking bench for triangle_raster_scan
//               against an arithmetic reference rasterizer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_triangle_raster_scan;
    localparam int W = 11;

    logic           clk, rst, start, out_ready;
    logic [W-1:0]   p1x, p1y, p2x, p2y, p3x, p3y;
    logic           busy, out_valid, done;
    logic [W-1:0]   out_x, out_y;
    logic [2*W-1:0] pix_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_x[$];
    int exp_y[$];
    int bbox_pts;
    bit seen99, seen45;

    triangle_raster_scan #(.COORD_W(W)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .done(done), .pix_count(pix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input longint obs, input longint expv);
        n_checks++;
        if (obs == expv) n_pass++;
        else $display("FAIL %s: got %0d required %0d", tag, obs, expv);
    endtask

    // Reference: every bounding-box point whose three edge values share a sign.
    task automatic build_model(input int ax, input int ay, input int bx, input int by,
                               input int cx, input int cy);
        int x0, x1, y0, y1, area, e1, e2, e3;
        exp_x.delete();
        exp_y.delete();
        x0 = ax; x1 = ax; y0 = ay; y1 = ay;
        if (bx < x0) x0 = bx; if (cx < x0) x0 = cx;
        if (bx > x1) x1 = bx; if (cx > x1) x1 = cx;
        if (by < y0) y0 = by; if (cy < y0) y0 = cy;
        if (by > y1) y1 = by; if (cy > y1) y1 = cy;
        bbox_pts = (x1 - x0 + 1) * (y1 - y0 + 1);
        area = (bx - ax) * (cy - ay) - (cx - ax) * (by - ay);
        if (area != 0) begin
            for (int y = y0; y <= y1; y++) begin
                for (int x = x0; x <= x1; x++) begin
                    e1 = (bx - ax) * (y - ay) - (by - ay) * (x - ax);
                    e2 = (cx - bx) * (y - by) - (cy - by) * (x - bx);
                    e3 = (ax - cx) * (y - cy) - (ay - cy) * (x - cx);
                    if ((e1 >= 0 && e2 >= 0 && e3 >= 0) || (e1 <= 0 && e2 <= 0 && e3 <= 0)) begin
                        exp_x.push_back(x);
                        exp_y.push_back(y);
                    end
                end
            end
        end
    endtask

    task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, input int rdy_pct,
                           input bit stall5, input bit poke, output int lat);
        int  cyc, budget, done_n, valid_n, held_x, held_y, stall_left, exp_n;
        bit  stalled, finished;
        build_model(ax, ay, bx, by, cx, cy);
        exp_n  = exp_x.size();
        budget = 30 * bbox_pts + 100;
        p1x = W'(ax); p1y = W'(ay); p2x = W'(bx); p2y = W'(by); p3x = W'(cx); p3y = W'(cy);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; done_n = 0; valid_n = 0; lat = 0;
        stalled = 1'b0; finished = 1'b0;
        stall_left = stall5 ? 5 : 0;
        while (!finished) begin
            if (cyc == 0) check("busy_run", busy, 1);
            if (done) begin
                done_n++;
                lat = cyc + 1;
                finished = 1'b1;
            end else if (cyc >= budget) begin
                check("timeout", 1, 0);
                finished = 1'b1;
            end else begin
                if (poke && cyc == 3) begin
                    start = 1'b1;
                    p1x = W'($urandom); p2y = W'($urandom); p3x = W'($urandom);
                end else begin
                    start = 1'b0;
                end
                if (out_valid) begin
                    valid_n++;
                    if (stalled) begin
                        check("hold_x", out_x, held_x);
                        check("hold_y", out_y, held_y);
                    end
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = ($urandom_range(99) < rdy_pct);
                    end
                    if (out_ready) begin
                        if (out_x == 9 && out_y == 9) seen99 = 1'b1;
                        if (out_x == 4 && out_y == 5) seen45 = 1'b1;
                        if (exp_x.size() == 0) begin
                            check("extra_pix", 1, 0);
                        end else begin
                            check("pix_x", out_x, exp_x.pop_front());
                            check("pix_y", out_y, exp_y.pop_front());
                        end
                        stalled = 1'b0;
                    end else begin
                        stalled = 1'b1;
                        held_x  = out_x;
                        held_y  = out_y;
                    end
                end else begin
                    if (stalled) check("valid_dropped", 0, 1);
                    stalled   = 1'b0;
                    out_ready = ($urandom_range(99) < rdy_pct);
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check("done_count", done_n, 1);
        check("pix_count", pix_count, exp_n);
        check("missing_pix", exp_x.size(), 0);
        if (exp_n == 0) check("valid_seen", valid_n, 0);
        out_ready = 1'b0;
        @(negedge clk);
        check("done_width", done, 0);
        check("busy_after", busy, 0);
    endtask

    initial begin
        int lat, dn;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        p1x = '0; p1y = '0; p2x = '0; p2y = '0; p3x = '0; p3y = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_out_x", out_x, 0);
        check("rst_out_y", out_y, 0);
        check("rst_pix_count", pix_count, 0);

        // Reset wins over a simultaneous start.
        p2x = W'(5); p3y = W'(5); start = 1'b1;
        @(negedge clk);
        check("rst_over_start", busy, 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);

        run_tri(0, 0, 3, 0, 0, 3, 100, 1'b0, 1'b0, lat);
        check("small_tri_count", pix_count, 10);

        seen99 = 1'b0; seen45 = 1'b0;
        run_tri(4, 9, 9, 5, 12, 11, 70, 1'b0, 1'b0, lat);
        check("emit_9_9", seen99, 1);
        check("skip_4_5", seen45, 0);
        seen99 = 1'b0; seen45 = 1'b0;
        run_tri(4, 9, 12, 11, 9, 5, 70, 1'b0, 1'b0, lat);
        check("rev_emit_9_9", seen99, 1);
        check("rev_skip_4_5", seen45, 0);

        run_tri(2, 2, 4, 4, 6, 6, 100, 1'b0, 1'b0, lat);
        check("collinear_latency", lat, 3);

        run_tri(1, 1, 8, 2, 3, 7, 100, 1'b1, 1'b0, lat);
        run_tri(0, 0, 6, 1, 2, 5, 80, 1'b0, 1'b1, lat);
        run_tri(2040, 2040, 2047, 2030, 2035, 2047, 60, 1'b0, 1'b0, lat);

        // Abort with a pixel pending in EMIT.
        p1x = W'(0); p1y = W'(0); p2x = W'(10); p2y = W'(0); p3x = W'(0); p3y = W'(10);
        out_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("pending_valid", out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_pix_count", pix_count, 0);
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        check("abort_no_done", dn, 0);
        run_tri(3, 1, 9, 4, 1, 8, 90, 1'b0, 1'b0, lat);

        for (int t = 0; t < 15; t++) begin
            run_tri($urandom_range(20), $urandom_range(20), $urandom_range(20),
                    $urandom_range(20), $urandom_range(20), $urandom_range(20),
                    $urandom_range(100, 30), 1'b0, 1'b0, lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/triangle_raster_scan.md
TRIANGLE_RASTER_SCAN -- requirements
Module: triangle_raster_scan

Interface
REQ-001 The block SHALL have parameter COORD_W, default 11, giving the unsigned coordinate width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to rasterize the triangle on p1x..p3y.
REQ-005 The block SHALL have ports p1x, p1y, p2x, p2y, p3x, p3y, input, COORD_W bits each: unsigned triangle vertices.
REQ-006 The block SHALL have port busy, output, 1 bit: high whenever the block is not IDLE.
REQ-007 The block SHALL have port out_valid, output, 1 bit: an inside pixel is presented.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the pixel.
REQ-009 The block SHALL have ports out_x and out_y, output, COORD_W bits each: presented pixel coordinates.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle end-of-triangle pulse.
REQ-011 The block SHALL have port pix_count, output, 2*COORD_W bits: number of pixels transferred for the current or last triangle.

Function
REQ-012 The FSM SHALL have states IDLE, SETUP, SCAN, EMIT and FIN.
REQ-013 In IDLE, start=1 SHALL latch all six vertex inputs, clear pix_count and enter SETUP; start SHALL be ignored in every other state.
REQ-014 SETUP SHALL last one cycle: it computes the bounding box xmin/xmax/ymin/ymax over the latched vertices, sets the current point to (xmin,ymin) and computes area = (p2x-p1x)*(p3y-p1y)-(p3x-p1x)*(p2y-p1y).
REQ-015 When area is zero, SETUP SHALL go directly to FIN without entering SCAN, and no pixel SHALL be emitted.
REQ-016 All edge and area arithmetic SHALL be signed: vertex differences sign-extended to COORD_W+1 bits, products and results held at 2*COORD_W+2 bits, with no truncation.
REQ-017 For point P, edge function E(a,b) SHALL be (bx-ax)*(Py-ay)-(by-ay)*(Px-ax), evaluated for edges (p1,p2), (p2,p3) and (p3,p1).
REQ-018 P SHALL be inside when all three edge functions are >=0 or all three are <=0, so edge and vertex pixels count as inside and vertex winding does not matter.
REQ-019 SCAN SHALL evaluate one point per cycle.
REQ-020 If the point is inside, SCAN SHALL load out_x/out_y, assert out_valid and enter EMIT.
REQ-021 If the point is outside, SCAN SHALL advance the point, or enter FIN if the point was the last one.
REQ-022 Scan order SHALL be raster: x increments from xmin to xmax, then x returns to xmin and y increments, ending at (xmax,ymax).
REQ-023 In EMIT, out_valid, out_x and out_y SHALL be held stable until the cycle in which out_valid and out_ready are both 1.
REQ-024 On that transfer cycle, EMIT SHALL increment pix_count, deassert out_valid the following cycle, advance the point and return to SCAN, or enter FIN if the point was (xmax,ymax).
REQ-025 out_valid SHALL never depend combinationally on out_ready.
REQ-026 FIN SHALL assert done for exactly one cycle and return to IDLE; pix_count SHALL hold its value until the next accepted start.
REQ-027 A degenerate single-pixel bounding box with nonzero area is impossible, so no special case SHALL be required for it.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL enter IDLE with busy=0, out_valid=0, done=0, out_x=0, out_y=0 and pix_count=0.
REQ-029 Reset in any state, including mid-scan or in EMIT with a pending pixel, SHALL abort the triangle with no done pulse and no further outputs.
REQ-030 rst SHALL have priority over start in the same cycle.

Verification
REQ-031 Triangle (0,0),(3,0),(0,3) with out_ready tied 1 SHALL emit exactly 10 pixels, those with x+y<=3, in raster order (0,0),(1,0),(2,0),(3,0),(0,1),...,(0,3); done SHALL pulse once and pix_count SHALL equal 10.
REQ-032 Triangle (4,9),(9,5),(12,11) SHALL emit (9,9) and SHALL NOT emit (4,5); the same vertices entered in reversed winding SHALL produce the identical pixel stream.
REQ-033 Collinear vertices (2,2),(4,4),(6,6) SHALL produce no out_valid, a done pulse 3 cycles after start, and pix_count=0.
REQ-034 Holding out_ready=0 for 5 cycles during EMIT SHALL keep out_x/out_y/out_valid stable, with no pixel lost or duplicated once out_ready rises.
REQ-035 A start pulse while busy SHALL be ignored, so the current triangle completes unchanged.
REQ-036 rst asserted mid-scan SHALL give busy=0 and out_valid=0 the next cycle with no done pulse, and a new start SHALL then rasterize normally.
